ram_arbiter: RTL and testbench

//  Shares the single-port data RAM (12-bit word addr, 32-bit data) between two requesters:
//  M0 = core load/store port, M1 = program loader / debug DMA. Per-cycle round-robin arbitration,

---
 rtl/ram_arbiter_pkg.sv | 15 +
 rtl/ram_arbiter_rr_pick2.sv | 22 ++
 rtl/ram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-master RAM arbiter: FSM encodings and master ids.
package ram_arbiter_pkg;

    // Ownership state: IDLE arbitrates every cycle, OWNx reserves the RAM for master x.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    // Master identifiers as stored in the "last granted" register.
    localparam logic M0_ID = 1'b0;
    localparam logic M1_ID = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins; on a tie the master that
// was not granted last wins. Purely combinational, one-hot (or zero) output.
module rr_pick2
    import ram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Pick one requester, alternating on ties.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == M0_ID) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port data RAM between the core load/store port (M0) and the
// loader/debug DMA (M1). Per-cycle round-robin, optional locked bursts bounded by
// MAX_BURST, and a one-cycle registered read response.
//
// Handshake: a master raises mN_req with stable fields and holds them until mN_gnt
// is seen high in the same cycle; req & gnt is one transfer. Grants are
// combinational, at most one per cycle, never without a request, and forced low
// while rst is asserted so nothing issued during reset produces a response.
// A granted read returns mN_rvalid for exactly one cycle on the next cycle.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_w_addr_o,
    output logic [DATA_W-1:0] ram_w_data_o,
    output logic              ram_r_en,
    output logic [ADDR_W-1:0] ram_r_addr_o,
    input  logic [DATA_W-1:0] ram_r_data_i,

    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    // With a burst limit of one, every beat is also the last, so a lock can never hold.
    localparam bit LOCK_OK = (MAX_BURST > 1);

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [1:0]         rvalid_q;
    logic [DATA_W-1:0]  rdata_q;

    logic [1:0]         pick_gnt;
    logic [1:0]         gnt;
    logic               gnt_id;
    logic               sel_we;
    logic               sel_lock;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    rr_pick2 u_pick (
        .req  ({m1_req, m0_req}),
        .last (last_q),
        .gnt  (pick_gnt)
    );

    // Grant selection, burst counting and ownership transitions.
    always_comb begin
        gnt     = 2'b00;
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        cnt_inc = cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: gnt = pick_gnt;
            ST_OWN0: gnt = {1'b0, m0_req};
            ST_OWN1: gnt = {m1_req, 1'b0};
            default: gnt = 2'b00;
        endcase
        if (!rst) begin
            gnt = 2'b00;
        end

        gnt_id    = gnt[1];
        sel_we    = gnt_id ? m1_we    : m0_we;
        sel_lock  = gnt_id ? m1_lock  : m0_lock;
        sel_addr  = gnt_id ? m1_addr  : m0_addr;
        sel_wdata = gnt_id ? m1_wdata : m0_wdata;

        if (|gnt) begin
            last_d = gnt_id;
            if (state_q == ST_IDLE) begin
                if (sel_lock && LOCK_OK) begin
                    state_d = (gnt_id == M1_ID) ? ST_OWN1 : ST_OWN0;
                    cnt_d   = CNT_W'(1);
                end
            end else if (!sel_lock || (cnt_inc == CNT_W'(MAX_BURST))) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_inc;
            end
        end else begin
            // Owner has gone quiet: drop the lock if it no longer asks for it.
            if ((state_q == ST_OWN0 && !m0_lock) || (state_q == ST_OWN1 && !m1_lock)) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end

        if (state_q != ST_IDLE && state_q != ST_OWN0 && state_q != ST_OWN1) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // RAM port drive from the granted master; idle RAM sees all zeros.
    always_comb begin
        ram_w_en     = 1'b0;
        ram_w_addr_o = '0;
        ram_w_data_o = '0;
        ram_r_en     = 1'b0;
        ram_r_addr_o = '0;
        if (|gnt) begin
            if (sel_we) begin
                ram_w_en     = 1'b1;
                ram_w_addr_o = sel_addr;
                ram_w_data_o = sel_wdata;
            end else begin
                ram_r_en     = 1'b1;
                ram_r_addr_o = sel_addr;
            end
        end
    end

    // State, counter and read-response registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            last_q   <= M1_ID;
            cnt_q    <= '0;
            rvalid_q <= 2'b00;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            rvalid_q <= gnt & {~m1_we, ~m0_we};
            if (ram_r_en) begin
                rdata_q <= ram_r_data_i;
            end
        end
    end

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = rdata_q;
    assign m1_rdata  = rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM (combinational read,
// write at the clock edge) preloaded with 0x1000_0000 + address.
module tb_ram_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;

    logic          clk;
    logic          rst;
    logic          m0_req, m0_we, m0_lock;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req, m1_we, m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          ram_w_en, ram_r_en;
    logic [AW-1:0] ram_w_addr_o, ram_r_addr_o;
    logic [DW-1:0] ram_w_data_o, ram_r_data_i;
    logic [1:0]    dbg_state;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req       (m0_req),
        .m0_we        (m0_we),
        .m0_lock      (m0_lock),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_gnt       (m0_gnt),
        .m0_rvalid    (m0_rvalid),
        .m0_rdata     (m0_rdata),
        .m1_req       (m1_req),
        .m1_we        (m1_we),
        .m1_lock      (m1_lock),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_gnt       (m1_gnt),
        .m1_rvalid    (m1_rvalid),
        .m1_rdata     (m1_rdata),
        .ram_w_en     (ram_w_en),
        .ram_w_addr_o (ram_w_addr_o),
        .ram_w_data_o (ram_w_data_o),
        .ram_r_en     (ram_r_en),
        .ram_r_addr_o (ram_r_addr_o),
        .ram_r_data_i (ram_r_data_i),
        .dbg_state    (dbg_state)
    );

    // Clock: 10 time-unit period, first rising edge at t=5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: preload, then write on rising edges.
    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = 32'h1000_0000 + i;
        end
        forever begin
            @(posedge clk);
            if (ram_w_en) begin
                mem[ram_w_addr_o] = ram_w_data_o;
            end
        end
    end

    assign ram_r_data_i = mem[ram_r_addr_o];

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic g0, input logic g1);
        chk({tag, "_gnt0"}, {31'd0, m0_gnt}, {31'd0, g0});
        chk({tag, "_gnt1"}, {31'd0, m1_gnt}, {31'd0, g1});
    endtask

    task automatic set_m0(input logic req, input logic we, input logic lock,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = wdata;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic lock,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wdata;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp0;

        // Reset held 3 cycles with both masters requesting.
        rst = 1'b0;
        set_m0(1'b1, 1'b0, 1'b0, 12'h010, 32'd0);
        set_m1(1'b1, 1'b0, 1'b0, 12'h020, 32'd0);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk_gnt("rst", 1'b0, 1'b0);
            chk("rst_w_en", {31'd0, ram_w_en}, 32'd0);
            chk("rst_r_en", {31'd0, ram_r_en}, 32'd0);
            tick();
            chk("rst_rvalid0", {31'd0, m0_rvalid}, 32'd0);
            chk("rst_rvalid1", {31'd0, m1_rvalid}, 32'd0);
            chk("rst_rdata", m0_rdata, 32'd0);
            chk("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        end
        rst = 1'b1;

        // Tie: continuous reads alternate starting with M0.
        for (int k = 0; k < 6; k++) begin
            exp0 = (k % 2 == 0);
            settle();
            chk_gnt("tie", exp0, !exp0);
            chk("tie_r_en", {31'd0, ram_r_en}, 32'd1);
            chk("tie_r_addr", {20'd0, ram_r_addr_o}, exp0 ? 32'h010 : 32'h020);
            tick();
            chk("tie_rvalid0", {31'd0, m0_rvalid}, {31'd0, exp0});
            chk("tie_rvalid1", {31'd0, m1_rvalid}, {31'd0, !exp0});
            chk("tie_rdata", m1_rdata, exp0 ? 32'h1000_0010 : 32'h1000_0020);
        end
        set_m0(1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
        set_m1(1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
        settle();
        chk_gnt("none", 1'b0, 1'b0);
        chk("none_r_en", {31'd0, ram_r_en}, 32'd0);
        chk("none_r_addr", {20'd0, ram_r_addr_o}, 32'd0);
        tick();
        chk("none_rvalid0", {31'd0, m0_rvalid}, 32'd0);
        chk("none_rvalid1", {31'd0, m1_rvalid}, 32'd0);
        chk("hold_rdata", m0_rdata, 32'h1000_0020);

        // Write by M1 then read-after-write by M0.
        set_m1(1'b1, 1'b1, 1'b0, 12'h0A5, 32'hDEAD_BEEF);
        settle();
        chk_gnt("wr", 1'b0, 1'b1);
        chk("wr_w_en", {31'd0, ram_w_en}, 32'd1);
        chk("wr_w_addr", {20'd0, ram_w_addr_o}, 32'h0A5);
        chk("wr_w_data", ram_w_data_o, 32'hDEAD_BEEF);
        chk("wr_r_en", {31'd0, ram_r_en}, 32'd0);
        tick();
        chk("wr_rvalid1", {31'd0, m1_rvalid}, 32'd0);
        set_m1(1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
        set_m0(1'b1, 1'b0, 1'b0, 12'h0A5, 32'd0);
        settle();
        chk_gnt("raw", 1'b1, 1'b0);
        chk("raw_r_addr", {20'd0, ram_r_addr_o}, 32'h0A5);
        tick();
        chk("raw_rvalid0", {31'd0, m0_rvalid}, 32'd1);
        chk("raw_rvalid1", {31'd0, m1_rvalid}, 32'd0);
        chk("raw_rdata", m0_rdata, 32'hDEAD_BEEF);

        // Locked burst: M1 goes once alone so M0 wins the first tie, then 8 beats.
        set_m0(1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
        set_m1(1'b1, 1'b0, 1'b0, 12'h040, 32'd0);
        settle();
        chk_gnt("pre_burst", 1'b0, 1'b1);
        tick();
        chk("pre_burst_rdata", m1_rdata, 32'h1000_0040);
        set_m0(1'b1, 1'b0, 1'b1, 12'h030, 32'd0);
        set_m1(1'b1, 1'b0, 1'b0, 12'h041, 32'd0);
        for (int k = 0; k < 8; k++) begin
            settle();
            chk_gnt("burst", 1'b1, 1'b0);
            tick();
            chk("burst_rvalid0", {31'd0, m0_rvalid}, 32'd1);
            chk("burst_rdata", m0_rdata, 32'h1000_0030);
            chk("burst_state", {30'd0, dbg_state}, {30'd0, (k < 7) ? S_OWN0 : S_IDLE});
        end
        settle();
        chk_gnt("release", 1'b0, 1'b1);
        chk("release_r_addr", {20'd0, ram_r_addr_o}, 32'h041);
        tick();
        chk("release_rvalid1", {31'd0, m1_rvalid}, 32'd1);
        chk("release_rdata", m1_rdata, 32'h1000_0041);
        chk("release_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        set_m0(1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
        set_m1(1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
        tick();

        // Early unlock: M0 goes once alone so M1 wins the first tie.
        set_m0(1'b1, 1'b0, 1'b0, 12'h060, 32'd0);
        settle();
        chk_gnt("pre_unlock", 1'b1, 1'b0);
        tick();
        set_m1(1'b1, 1'b0, 1'b1, 12'h050, 32'd0);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) m1_lock = 1'b0;
            settle();
            chk_gnt("unlock_beat", 1'b0, 1'b1);
            tick();
            chk("unlock_rvalid1", {31'd0, m1_rvalid}, 32'd1);
            chk("unlock_rdata", m1_rdata, 32'h1000_0050);
            chk("unlock_state", {30'd0, dbg_state}, {30'd0, (k < 2) ? S_OWN1 : S_IDLE});
        end
        set_m1(1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
        settle();
        chk_gnt("unlock_m0", 1'b1, 1'b0);
        tick();
        chk("unlock_m0_rvalid0", {31'd0, m0_rvalid}, 32'd1);
        chk("unlock_m0_rdata", m0_rdata, 32'h1000_0060);

        // Abandoned lock: owner idles with lock held, then drops it.
        set_m0(1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
        set_m1(1'b1, 1'b0, 1'b1, 12'h051, 32'd0);
        settle();
        chk_gnt("abandon_take", 1'b0, 1'b1);
        tick();
        chk("abandon_take_state", {30'd0, dbg_state}, {30'd0, S_OWN1});
        set_m1(1'b0, 1'b0, 1'b1, 12'h000, 32'd0);
        set_m0(1'b1, 1'b0, 1'b0, 12'h061, 32'd0);
        settle();
        chk_gnt("abandon_hold", 1'b0, 1'b0);
        tick();
        chk("abandon_hold_state", {30'd0, dbg_state}, {30'd0, S_OWN1});
        m1_lock = 1'b0;
        settle();
        chk_gnt("abandon_drop", 1'b0, 1'b0);
        tick();
        chk("abandon_drop_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        chk("abandon_drop_rvalid0", {31'd0, m0_rvalid}, 32'd0);
        settle();
        chk_gnt("abandon_after", 1'b1, 1'b0);
        tick();
        chk("abandon_after_rdata", m0_rdata, 32'h1000_0061);

        // Reset during beat 3 of an M0 locked read burst.
        set_m0(1'b1, 1'b0, 1'b1, 12'h070, 32'd0);
        settle();
        chk_gnt("rstb_beat1", 1'b1, 1'b0);
        tick();
        chk("rstb_beat1_state", {30'd0, dbg_state}, {30'd0, S_OWN0});
        settle();
        tick();
        chk("rstb_beat2_rvalid0", {31'd0, m0_rvalid}, 32'd1);
        chk("rstb_beat2_rdata", m0_rdata, 32'h1000_0070);
        rst = 1'b0;
        settle();
        chk_gnt("rstb_beat3", 1'b0, 1'b0);
        chk("rstb_beat3_r_en", {31'd0, ram_r_en}, 32'd0);
        tick();
        chk("rstb_rvalid0", {31'd0, m0_rvalid}, 32'd0);
        chk("rstb_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        chk("rstb_rdata", m0_rdata, 32'd0);
        rst = 1'b1;
        set_m0(1'b1, 1'b0, 1'b0, 12'h080, 32'd0);
        set_m1(1'b1, 1'b0, 1'b0, 12'h090, 32'd0);
        settle();
        chk_gnt("rstb_tie", 1'b1, 1'b0);
        tick();
        chk("rstb_tie_rvalid0", {31'd0, m0_rvalid}, 32'd1);
        chk("rstb_tie_rdata", m0_rdata, 32'h1000_0080);

        set_m0(1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
        set_m1(1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
